e06_input_sequencer: RTL and testbench
======================================

// Module: e06_input_sequencer
// PURPOSE
//   Upstream stimulus stage for the E06 4-bit combinational block.
//   Produces the four input bits a,b,c,d from one of two sources:
//   - MANUAL mode: four debounced board switches.
//   - AUTO mode: a free-running 0..15 sweep.
//   Outputs drive a,b,c,d of the downstream block directly. All outputs are registered.
// PARAMETERS
//   DEBOUNCE_CYCLES  16  consecutive mismatching cycles before a switch bit is accepted (>=1)
//   STEP_CYCLES       8  clk cycles each AUTO code is held (>=1; 1 = increment every cycle)
// PORTS
//   clk      in   1  system clock, rising edge
//   rst_n    in   1  asynchronous active-low reset
//   sw       in   4  raw switches, async; sw[3]->a ... sw[0]->d
//   auto_en  in   1  async level; 1 = AUTO sweep, 0 = MANUAL switches
//   a        out  1  code[3]
//   b        out  1  code[2]
//   c        out  1  code[1]
//   d        out  1  code[0]
//   code     out  4  current 4-bit code, MSB = a
//   upd      out  1  1-cycle pulse, high in the same cycle a new code value first appears
//   wrap     out  1  1-cycle pulse, high with the AUTO 15->0 transition
// BEHAVIOUR
//   Reset (rst_n=0, takes effect immediately with no clock edge):
//     - Clears sync flops, debounced value, debounce/tick counters, code, upd and wrap to 0.
//     - State goes to MANUAL.
//   Synchronizer:
//     - sw and auto_en each pass through 2 flops.
//     - All logic below uses the synced values only.
//   Debounce, per bit, independently:
//     - Counter increments on each edge where sync bit != stable bit.
//     - On the DEBOUNCE_CYCLES-th consecutive mismatch: stable <= sync bit, counter <= 0.
//     - Any edge with sync bit == stable bit clears the counter.
//   FSM:
//     - MANUAL -> AUTO when synced auto_en = 1.
//     - AUTO -> MANUAL when synced auto_en = 0.
//   MANUAL:
//     - code <= stable each edge.
//     - Latency from a clean sw change to code = exactly 2 + DEBOUNCE_CYCLES + 1 edges.
//   Entering AUTO (transition edge):
//     - code <= 0, tick <= 0.
//     - Increments then occur every STEP_CYCLES edges, counted from the transition edge.
//   AUTO, when tick = STEP_CYCLES-1:
//     - code <= code+1, wrapping mod 16; tick <= 0.
//     - wrap = 1 for the cycle code becomes 0 after 15.
//   Leaving AUTO (transition edge):
//     - No increment and no wrap, even if the tick is terminal on that edge (mode change wins).
//     - code <= stable switches on that edge.
//   upd:
//     - Registered with code: 1 iff code changed on the previous edge.
//     - Reloading an identical value (e.g. entering AUTO with code already 0) gives no upd.
//   a/b/c/d:
//     - Pure bit slices of the code register; no extra latency.
//     - d is code[0], c is code[1]; they are never aliased.
//   Debounce keeps running in AUTO, so stable is current on return to MANUAL.
// TESTING
//   1 reset: AUTO, code=9, rst_n low between edges -> code=0, a..d=0, upd=0, wrap=0 immediately; MANUAL.
//   2 manual: DEBOUNCE=4, sw=4'b1010 held -> 7 edges later code=1010, a=1 b=0 c=1 d=0, one upd pulse.
//   3 glitch: DEBOUNCE=4, sw[0] high for 3 cycles then low -> code unchanged, upd never asserts.
//   4 sweep: STEP=8, auto_en=1 for 300 cycles:
//     - code steps 0,1..15,0 with each value held 8 cycles.
//     - upd on every step; wrap exactly once per 128 cycles, coincident with code=0.
//   5 exit on terminal tick: auto_en drops so synced 0 lands on the tick=7 edge with code=5, sw=0011
//     -> code=0011, no 5->6, wrap=0.
//   6 bit order: sw=0001 -> d=1, c=0, b=0, a=0; sw=0010 -> c=1, d=0 (catches c/d swap).

Source files
------------

// File: rtl/e06_input_sequencer.sv
// Stimulus source for the E06 4-bit block: debounced switches (MANUAL) or a
// free-running 0..15 sweep (AUTO), presented as a registered 4-bit code.
module e06_input_sequencer #(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned STEP_CYCLES     = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] sw,
  input  logic       auto_en,
  output logic       a,
  output logic       b,
  output logic       c,
  output logic       d,
  output logic [3:0] code,
  output logic       upd,
  output logic       wrap
);

  localparam int unsigned CNT_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int unsigned TICK_W = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(STEP_CYCLES - 1);

  typedef enum logic {
    ST_MANUAL = 1'b0,
    ST_AUTO   = 1'b1
  } state_t;

  logic [3:0]        r_sw_s1;
  logic [3:0]        r_sw_s2;
  logic              r_auto_s1;
  logic              r_auto_s2;
  logic [3:0]        r_stable;
  logic [CNT_W-1:0]  r_db_cnt [4];
  state_t            r_state;
  logic [TICK_W-1:0] r_tick;
  logic [3:0]        r_code;
  logic              r_upd;
  logic              r_wrap;
  logic [3:0]        w_code_inc;

  assign w_code_inc = r_code + 4'd1;

  // Two-flop synchronizers for the asynchronous switch and mode inputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sw_s1   <= '0;
      r_sw_s2   <= '0;
      r_auto_s1 <= 1'b0;
      r_auto_s2 <= 1'b0;
    end else begin
      r_sw_s1   <= sw;
      r_sw_s2   <= r_sw_s1;
      r_auto_s1 <= auto_en;
      r_auto_s2 <= r_auto_s1;
    end
  end

  // Per-bit debounce: accept a new level after DEBOUNCE_CYCLES consecutive mismatches
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stable <= '0;
      for (int i = 0; i < 4; i++) begin
        r_db_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (r_sw_s2[i] != r_stable[i]) begin
          if (r_db_cnt[i] == CNT_LAST) begin
            r_stable[i] <= r_sw_s2[i];
            r_db_cnt[i] <= '0;
          end else begin
            r_db_cnt[i] <= r_db_cnt[i] + CNT_W'(1);
          end
        end else begin
          r_db_cnt[i] <= '0;
        end
      end
    end
  end

  // Mode FSM and code register; a mode change always takes priority over a step
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_MANUAL;
      r_tick  <= '0;
      r_code  <= '0;
      r_upd   <= 1'b0;
      r_wrap  <= 1'b0;
    end else begin
      r_wrap <= 1'b0;
      unique case (r_state)
        ST_MANUAL: begin
          r_tick <= '0;
          if (r_auto_s2) begin
            r_state <= ST_AUTO;
            r_code  <= '0;
            r_upd   <= (r_code != 4'd0);
          end else begin
            r_code <= r_stable;
            r_upd  <= (r_stable != r_code);
          end
        end
        ST_AUTO: begin
          if (!r_auto_s2) begin
            r_state <= ST_MANUAL;
            r_tick  <= '0;
            r_code  <= r_stable;
            r_upd   <= (r_stable != r_code);
          end else if (r_tick == TICK_LAST) begin
            r_tick <= '0;
            r_code <= w_code_inc;
            r_upd  <= 1'b1;
            r_wrap <= (r_code == 4'hF);
          end else begin
            r_tick <= r_tick + TICK_W'(1);
            r_upd  <= 1'b0;
          end
        end
        default: begin
          r_state <= ST_MANUAL;
          r_upd   <= 1'b0;
        end
      endcase
    end
  end

  assign code = r_code;
  assign a    = r_code[3];
  assign b    = r_code[2];
  assign c    = r_code[1];
  assign d    = r_code[0];
  assign upd  = r_upd;
  assign wrap = r_wrap;

endmodule

// File: tb/tb_e06_input_sequencer.sv
// Directed bench for e06_input_sequencer with DEBOUNCE_CYCLES=4, STEP_CYCLES=8.
module tb_e06_input_sequencer;

  logic       clk;
  logic       rst_n;
  logic [3:0] sw;
  logic       auto_en;
  logic       a, b, c, d;
  logic [3:0] code;
  logic       upd;
  logic       wrap;

  int n_pass;
  int n_total;

  e06_input_sequencer #(
    .DEBOUNCE_CYCLES(4),
    .STEP_CYCLES    (8)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .sw     (sw),
    .auto_en(auto_en),
    .a      (a),
    .b      (b),
    .c      (c),
    .d      (d),
    .code   (code),
    .upd    (upd),
    .wrap   (wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Advance n rising edges, then sample 1 time unit later
  task automatic edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    rst_n   = 1'b0;
    sw      = 4'b0000;
    auto_en = 1'b0;

    // Power-on reset
    #3;
    check("por_code", 8'(code), 8'h0);
    check("por_upd", 8'(upd), 8'h0);
    @(negedge clk);
    rst_n = 1'b1;
    edges(1);
    check("idle_code", 8'(code), 8'h0);
    check("idle_wrap", 8'(wrap), 8'h0);

    // Manual: 1010 appears exactly 7 edges after the switch change
    sw = 4'b1010;
    edges(6);
    check("man_early_code", 8'(code), 8'h0);
    check("man_early_upd", 8'(upd), 8'h0);
    edges(1);
    check("man_code", 8'(code), 8'hA);
    check("man_abcd", 8'({a, b, c, d}), 8'hA);
    check("man_upd", 8'(upd), 8'h1);
    edges(1);
    check("man_upd_once", 8'(upd), 8'h0);
    check("man_hold", 8'(code), 8'hA);

    // Bit order
    sw = 4'b0001;
    edges(7);
    check("bit_d1", 8'({a, b, c, d}), 8'h1);
    check("bit_d1_d", 8'(d), 8'h1);
    check("bit_d1_c", 8'(c), 8'h0);
    sw = 4'b0010;
    edges(7);
    check("bit_c1_c", 8'(c), 8'h1);
    check("bit_c1_d", 8'(d), 8'h0);
    check("bit_c1_code", 8'(code), 8'h2);

    // Glitch: sw[0] high for 3 cycles is rejected
    sw = 4'b0011;
    edges(3);
    sw = 4'b0010;
    for (int i = 0; i < 10; i++) begin
      edges(1);
      check("glitch_code", 8'(code), 8'h2);
      check("glitch_upd", 8'(upd), 8'h0);
    end

    // Sweep: entry on the 3rd edge, then a step every 8 edges
    sw      = 4'b0011;
    auto_en = 1'b1;
    edges(2);
    check("auto_pre_code", 8'(code), 8'h2);
    edges(1);
    check("auto_entry_code", 8'(code), 8'h0);
    check("auto_entry_upd", 8'(upd), 8'h1);
    for (int k = 1; k <= 20; k++) begin
      for (int j = 0; j < 7; j++) begin
        edges(1);
        check("sweep_hold", 8'(code), 8'((k - 1) % 16));
        check("sweep_hold_upd", 8'(upd), 8'h0);
        check("sweep_hold_wrap", 8'(wrap), 8'h0);
      end
      edges(1);
      check("sweep_step", 8'(code), 8'(k % 16));
      check("sweep_step_upd", 8'(upd), 8'h1);
      check("sweep_step_wrap", 8'(wrap), (k == 16) ? 8'h1 : 8'h0);
    end

    // Exit with synced auto_en=0 landing on the terminal tick at code=5
    edges(8);
    check("exit_pre_code", 8'(code), 8'h5);
    edges(5);
    auto_en = 1'b0;
    edges(2);
    check("exit_still_5", 8'(code), 8'h5);
    edges(1);
    check("exit_code", 8'(code), 8'h3);
    check("exit_wrap", 8'(wrap), 8'h0);
    check("exit_upd", 8'(upd), 8'h1);
    edges(1);
    check("exit_hold", 8'(code), 8'h3);
    check("exit_upd_off", 8'(upd), 8'h0);

    // Reset in AUTO with code=9, asserted between edges
    auto_en = 1'b1;
    edges(3);
    check("re_auto_code", 8'(code), 8'h0);
    edges(72);
    check("re_auto_9", 8'(code), 8'h9);
    check("re_auto_9_upd", 8'(upd), 8'h1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_code", 8'(code), 8'h0);
    check("rst_abcd", 8'({a, b, c, d}), 8'h0);
    check("rst_upd", 8'(upd), 8'h0);
    check("rst_wrap", 8'(wrap), 8'h0);
    auto_en = 1'b0;
    sw      = 4'b0011;
    @(negedge clk);
    rst_n = 1'b1;
    edges(6);
    check("rst_manual_early", 8'(code), 8'h0);
    edges(1);
    check("rst_manual_code", 8'(code), 8'h3);
    check("rst_manual_upd", 8'(upd), 8'h1);
    edges(8);
    check("rst_manual_hold", 8'(code), 8'h3);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
